pd_st_to_mem_writer: RTL and testbench

PD_ST_TO_MEM_WRITER -- requirements
Module: pd_st_to_mem_writer

---
 rtl/pd_memwr_pkg.sv | 31 +++
 rtl/pd_byte_packer.sv | 73 +++++++
 rtl/pd_st_to_mem_writer.sv | 115 +++++++++++
 tb/tb_pd_st_to_mem_writer.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/pd_memwr_pkg.sv
// Shared types and constants for the stream-to-memory writer.
// Optional build macro PD_MEMWR_WRAP_EN is consumed by pd_st_to_mem_writer.
package pd_memwr_pkg;

    localparam int ADDR_W = 10;
    localparam int WCNT_W = 11;
    localparam logic [WCNT_W-1:0] WCNT_SAT = 11'd1024;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FILL  = 2'd1,
        ST_WRITE = 2'd2,
        ST_FULL  = 2'd3
    } state_e;

    localparam logic [3:0] BE_1B = 4'b0001;
    localparam logic [3:0] BE_2B = 4'b0011;
    localparam logic [3:0] BE_3B = 4'b0111;
    localparam logic [3:0] BE_4B = 4'b1111;

    // Byte lanes enabled when the terminating byte lands in the given lane.
    function automatic logic [3:0] be_for_lane(input logic [1:0] lane);
        case (lane)
            2'd0:    return BE_1B;
            2'd1:    return BE_2B;
            2'd2:    return BE_3B;
            default: return BE_4B;
        endcase
    endfunction

endpackage

// File: rtl/pd_byte_packer.sv
// Accumulates stream bytes little-endian into a 32-bit word and captures the
// finished word plus its byte enables when the word terminates.
module pd_byte_packer
    import pd_memwr_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        clear,
    input  logic        accept,
    input  logic [7:0]  data,
    input  logic        eop,
    output logic        done,
    output logic [31:0] word,
    output logic [3:0]  be
);

    logic [1:0]  lane_q, lane_d;
    logic [7:0]  acc_q [3];
    logic [31:0] packed_w;
    logic [31:0] word_q;
    logic [3:0]  be_q;

    assign done = accept & (eop | (lane_q == 2'd3));

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            if (gi < 3) begin : g_store
                always_ff @(posedge clk or posedge reset) begin
                    if (reset) begin
                        acc_q[gi] <= 8'h00;
                    end else if (clear) begin
                        acc_q[gi] <= 8'h00;
                    end else if (accept && !done && lane_q == 2'(gi)) begin
                        acc_q[gi] <= data;
                    end
                end
                // Lanes above the current byte are zeroed so partial words are clean.
                assign packed_w[gi*8 +: 8] = (2'(gi) < lane_q)  ? acc_q[gi] :
                                             (2'(gi) == lane_q) ? data      : 8'h00;
            end else begin : g_top
                assign packed_w[gi*8 +: 8] = (lane_q == 2'd3) ? data : 8'h00;
            end
        end
    endgenerate

    always_comb begin
        lane_d = lane_q;
        if (clear || done) begin
            lane_d = 2'd0;
        end else if (accept) begin
            lane_d = lane_q + 2'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            lane_q <= 2'd0;
            word_q <= 32'h0;
            be_q   <= 4'b0000;
        end else begin
            lane_q <= lane_d;
            if (done && !clear) begin
                word_q <= packed_w;
                be_q   <= be_for_lane(lane_q);
            end
        end
    end

    assign word = word_q;
    assign be   = be_q;

endmodule

// File: rtl/pd_st_to_mem_writer.sv
// Streams bytes into consecutive 32-bit words of an on-chip memory.
// Define PD_MEMWR_WRAP_EN to wrap the address at the region end instead of stopping.
module pd_st_to_mem_writer
    import pd_memwr_pkg::*;
#(
    parameter int BASE_ADDR = 0,
    parameter int DEPTH     = 1024
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [7:0]        snk_data,
    input  logic              snk_valid,
    output logic              snk_ready,
    input  logic              snk_eop,
    output logic [ADDR_W-1:0] mem_address,
    output logic [3:0]        mem_byteenable,
    output logic              mem_chipselect,
    output logic              mem_write,
    output logic [31:0]       mem_writedata,
    output logic              mem_clken,
    output logic [WCNT_W-1:0] words_written,
    output logic              full
);

    localparam logic [ADDR_W-1:0] BASE_A = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W-1:0] LAST_A = ADDR_W'(BASE_ADDR + DEPTH - 1);

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [WCNT_W-1:0]   wcnt_q, wcnt_d;
    logic                accept;
    logic                word_done;
    logic                strobe;

    assign snk_ready = ~reset & ~start & ((state_q == ST_IDLE) | (state_q == ST_FILL));
    assign accept    = snk_valid & snk_ready;
    // A start landing on the WRITE cycle cancels that word as well.
    assign strobe    = (state_q == ST_WRITE) & ~start;

    pd_byte_packer u_packer (
        .clk    (clk),
        .reset  (reset),
        .clear  (start),
        .accept (accept),
        .data   (snk_data),
        .eop    (snk_eop),
        .done   (word_done),
        .word   (mem_writedata),
        .be     (mem_byteenable)
    );

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        wcnt_d  = wcnt_q;
        if (start) begin
            state_d = ST_IDLE;
            addr_d  = BASE_A;
            wcnt_d  = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (word_done) begin
                        state_d = ST_WRITE;
                    end else if (accept) begin
                        state_d = ST_FILL;
                    end
                end
                ST_FILL: begin
                    if (word_done) begin
                        state_d = ST_WRITE;
                    end
                end
                ST_WRITE: begin
                    if (wcnt_q != WCNT_SAT) begin
                        wcnt_d = wcnt_q + 1'b1;
                    end
                    if (addr_q == LAST_A) begin
`ifdef PD_MEMWR_WRAP_EN
                        state_d = ST_IDLE;
                        addr_d  = BASE_A;
`else
                        state_d = ST_FULL;
`endif
                    end else begin
                        state_d = ST_IDLE;
                        addr_d  = addr_q + 1'b1;
                    end
                end
                default: state_d = ST_FULL;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            addr_q  <= BASE_A;
            wcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wcnt_q  <= wcnt_d;
        end
    end

    assign mem_address    = addr_q;
    assign mem_write      = strobe;
    assign mem_chipselect = strobe;
    assign mem_clken      = 1'b1;
    assign words_written  = wcnt_q;
    assign full           = (state_q == ST_FULL);

endmodule

// File: tb/tb_pd_st_to_mem_writer.sv
// Directed bench for pd_st_to_mem_writer; honours PD_MEMWR_WRAP_EN when defined.
module tb_pd_st_to_mem_writer;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [7:0]  snk_data;
    logic        snk_valid;
    logic        snk_ready;
    logic        snk_eop;
    logic [9:0]  mem_address;
    logic [3:0]  mem_byteenable;
    logic        mem_chipselect;
    logic        mem_write;
    logic [31:0] mem_writedata;
    logic        mem_clken;
    logic [10:0] words_written;
    logic        full;

    int n_vec = 0;
    int n_err = 0;
    int wr_cnt = 0;
    int wr_base;

    always #5 clk = ~clk;

    pd_st_to_mem_writer #(.BASE_ADDR(0), .DEPTH(1024)) dut (
        .clk            (clk),
        .reset          (reset),
        .start          (start),
        .snk_data       (snk_data),
        .snk_valid      (snk_valid),
        .snk_ready      (snk_ready),
        .snk_eop        (snk_eop),
        .mem_address    (mem_address),
        .mem_byteenable (mem_byteenable),
        .mem_chipselect (mem_chipselect),
        .mem_write      (mem_write),
        .mem_writedata  (mem_writedata),
        .mem_clken      (mem_clken),
        .words_written  (words_written),
        .full           (full)
    );

    always @(posedge clk) begin
        if (mem_write) wr_cnt <= wr_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
        $display("vec %0d %s: observed 0x%08h expected 0x%08h", n_vec, tag, obs, exp);
    endtask

    // Present one byte and hold it until accepted; returns 1 ns after the accepting edge.
    task automatic send(input logic [7:0] d, input logic e);
        int t;
        @(negedge clk);
        snk_data  = d;
        snk_eop   = e;
        snk_valid = 1'b1;
        t = 0;
        while (!snk_ready && t < 20) begin
            @(negedge clk);
            t++;
        end
        if (t >= 20) check("ready_timeout", {31'b0, snk_ready}, 32'd1);
        @(posedge clk);
        #1;
        snk_valid = 1'b0;
        snk_eop   = 1'b0;
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; snk_data = 8'h00; snk_valid = 1'b0; snk_eop = 1'b0;
        #1;
        check("rst_addr",  {22'b0, mem_address}, 32'd0);
        check("rst_write", {31'b0, mem_write}, 32'd0);
        check("rst_cs",    {31'b0, mem_chipselect}, 32'd0);
        check("rst_be",    {28'b0, mem_byteenable}, 32'h0);
        check("rst_data",  mem_writedata, 32'h0);
        check("rst_ww",    {21'b0, words_written}, 32'd0);
        check("rst_full",  {31'b0, full}, 32'd0);
        check("rst_ready", {31'b0, snk_ready}, 32'd0);
        check("clken",     {31'b0, mem_clken}, 32'd1);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        #1;
        check("ready_after_rst", {31'b0, snk_ready}, 32'd1);

        // Full word, no bubbles
        send(8'h11, 1'b0); send(8'h22, 1'b0); send(8'h33, 1'b0); send(8'h44, 1'b0);
        @(negedge clk);
        check("w1_write", {31'b0, mem_write}, 32'd1);
        check("w1_cs",    {31'b0, mem_chipselect}, 32'd1);
        check("w1_data",  mem_writedata, 32'h44332211);
        check("w1_be",    {28'b0, mem_byteenable}, 32'hF);
        check("w1_addr",  {22'b0, mem_address}, 32'd0);
        check("w1_ready", {31'b0, snk_ready}, 32'd0);
        @(negedge clk);
        check("w1_ww",    {21'b0, words_written}, 32'd1);
        check("w1_addr_inc", {22'b0, mem_address}, 32'd1);
        check("w1_done",  {31'b0, mem_write}, 32'd0);

        // Two-byte EOP word
        send(8'hAA, 1'b0); send(8'hBB, 1'b1);
        @(negedge clk);
        check("w2_write", {31'b0, mem_write}, 32'd1);
        check("w2_data",  mem_writedata, 32'h0000BBAA);
        check("w2_be",    {28'b0, mem_byteenable}, 32'h3);
        check("w2_addr",  {22'b0, mem_address}, 32'd1);
        @(negedge clk);
        check("w2_idle_ready", {31'b0, snk_ready}, 32'd1);
        check("w2_ww",    {21'b0, words_written}, 32'd2);

        // Start during FILL with a coincident byte
        send(8'h66, 1'b0);
        @(negedge clk);
        start = 1'b1; snk_valid = 1'b1; snk_data = 8'h55;
        #1;
        check("st_ready_low", {31'b0, snk_ready}, 32'd0);
        @(posedge clk);
        #1;
        start = 1'b0; snk_valid = 1'b0;
        @(negedge clk);
        check("st_no_write", {31'b0, mem_write}, 32'd0);
        check("st_addr",  {22'b0, mem_address}, 32'd0);
        check("st_ww",    {21'b0, words_written}, 32'd0);
        send(8'h77, 1'b1);
        @(negedge clk);
        check("st_w_write", {31'b0, mem_write}, 32'd1);
        check("st_w_data",  mem_writedata, 32'h00000077);
        check("st_w_be",    {28'b0, mem_byteenable}, 32'h1);
        check("st_w_addr",  {22'b0, mem_address}, 32'd0);

        // Fill the whole region
        pulse_start();
        wr_base = wr_cnt;
        for (int i = 0; i < 4096; i++) send(8'(i), 1'b0);
        @(negedge clk);
        check("last_write", {31'b0, mem_write}, 32'd1);
        check("last_addr",  {22'b0, mem_address}, 32'd1023);
        check("last_data",  mem_writedata, 32'hFFFEFDFC);
        @(negedge clk);
        check("fill_strobes", wr_cnt - wr_base, 32'd1024);
        check("fill_ww",    {21'b0, words_written}, 32'd1024);
`ifdef PD_MEMWR_WRAP_EN
        check("wrap_full",  {31'b0, full}, 32'd0);
        check("wrap_addr",  {22'b0, mem_address}, 32'd0);
        send(8'h01, 1'b0); send(8'h02, 1'b0); send(8'h03, 1'b0); send(8'h04, 1'b0);
        @(negedge clk);
        check("wrap_write", {31'b0, mem_write}, 32'd1);
        check("wrap_w_addr", {22'b0, mem_address}, 32'd0);
        check("wrap_w_data", mem_writedata, 32'h04030201);
        @(negedge clk);
        check("wrap_ww_sat", {21'b0, words_written}, 32'd1024);
        check("wrap_full2", {31'b0, full}, 32'd0);
        check("wrap_strobes", wr_cnt - wr_base, 32'd1025);
`else
        check("full_set",   {31'b0, full}, 32'd1);
        check("full_ready", {31'b0, snk_ready}, 32'd0);
        snk_data = 8'h99; snk_valid = 1'b1;
        repeat (6) @(negedge clk);
        check("full_hold_ready", {31'b0, snk_ready}, 32'd0);
        check("full_hold",  {31'b0, full}, 32'd1);
        check("full_no_strobe", wr_cnt - wr_base, 32'd1024);
        check("full_ww",    {21'b0, words_written}, 32'd1024);
        snk_valid = 1'b0;
`endif

        // Reset asserted during WRITE
        pulse_start();
        check("start_clears_full", {31'b0, full}, 32'd0);
        send(8'hC1, 1'b0); send(8'hC2, 1'b0); send(8'hC3, 1'b0); send(8'hC4, 1'b0);
        @(negedge clk);
        check("rw_write_before", {31'b0, mem_write}, 32'd1);
        #2;
        reset = 1'b1;
        #1;
        check("rw_write", {31'b0, mem_write}, 32'd0);
        check("rw_cs",    {31'b0, mem_chipselect}, 32'd0);
        check("rw_be",    {28'b0, mem_byteenable}, 32'h0);
        check("rw_data",  mem_writedata, 32'h0);
        check("rw_addr",  {22'b0, mem_address}, 32'd0);
        check("rw_ww",    {21'b0, words_written}, 32'd0);
        check("rw_full",  {31'b0, full}, 32'd0);
        check("rw_ready", {31'b0, snk_ready}, 32'd0);
        wr_base = wr_cnt;
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("rw_ready_after", {31'b0, snk_ready}, 32'd1);
        @(negedge clk);
        check("rw_no_strobe", wr_cnt - wr_base, 32'd0);
        check("rw_ww_after", {21'b0, words_written}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
